// File: rtl/fifo_pkg.sv
// Shared FIFO pointer types and helpers for the read- and write-side controllers.
// Pointers carry a wrap bit above the address so that any DEPTH, including non-power-of-2, is supported.
package fifo_pkg;

  localparam int unsigned FIFO_MAX_ADDR_W = 31;

  typedef logic [FIFO_MAX_ADDR_W-1:0] addr_t;
  typedef logic [FIFO_MAX_ADDR_W:0]   ptr_t;

  // The wrap bit sits at position addr_w. The address wraps at depth-1, not at a power of 2.
  function automatic ptr_t next_ptr(input ptr_t ptr, input int unsigned depth,
                                    input int unsigned addr_w);
    ptr_t  wrap_bit;
    ptr_t  wrap;
    addr_t mask;
    addr_t addr;
    wrap_bit = ptr_t'(1) << addr_w;
    mask     = addr_t'(wrap_bit - ptr_t'(1));
    addr     = addr_t'(ptr) & mask;
    wrap     = ptr & wrap_bit;
    if (addr == addr_t'(depth - 1)) begin
      addr = '0;
      wrap = wrap ^ wrap_bit;
    end else begin
      addr = addr + addr_t'(1);
    end
    return ptr_t'(addr) | wrap;
  endfunction

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/fifo_level_calc.sv
// Combinational occupancy, empty and almost-empty from a pair of wrap-bit pointers.
module fifo_level_calc #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ADDR_W    = $clog2(DEPTH),
  parameter int unsigned AE_THRESH = 2
) (
  input  logic [ADDR_W:0] rd_ptr,
  input  logic [ADDR_W:0] wr_ptr,
  output logic [ADDR_W:0] level,
  output logic            empty,
  output logic            almost_empty
);

  localparam int unsigned LW = ADDR_W + 1;

  logic [ADDR_W:0] rd_addr;
  logic [ADDR_W:0] wr_addr;

  always_comb begin
    rd_addr = {1'b0, rd_ptr[ADDR_W-1:0]};
    wr_addr = {1'b0, wr_ptr[ADDR_W-1:0]};
    // With differing wrap bits the writer is one lap ahead, so DEPTH is added back.
    if (rd_ptr[ADDR_W] == wr_ptr[ADDR_W]) begin
      level = wr_addr - rd_addr;
    end else begin
      level = LW'(DEPTH) - rd_addr + wr_addr;
    end
  end

  assign empty        = (rd_ptr == wr_ptr);
  assign almost_empty = (level <= LW'(AE_THRESH));

endmodule

// File: rtl/fifo_rd_ptr_ctrl.sv
// Read-side pointer controller for the single-clock FIFO: pop handling, memory read strobe, status, underflow.
// FIFO_RD_GRAY_EN adds a registered Gray-coded copy of rd_ptr (power-of-2 DEPTH only).
module fifo_rd_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ADDR_W    = $clog2(DEPTH),
  parameter int unsigned AE_THRESH = 2,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pop,
  input  logic [ADDR_W:0]      wr_ptr,
  input  logic                 err_clr,
  output logic                 ena_rd,
  output logic [ADDR_W-1:0]    addr_rd,
  output logic [ADDR_W:0]      rd_ptr,
  output logic                 rd_valid,
  output logic                 empty,
  output logic                 almost_empty,
  output logic [ADDR_W:0]      level,
  output logic                 led_error,
  output logic [ERR_CNT_W-1:0] err_cnt
`ifdef FIFO_RD_GRAY_EN
  ,
  output logic [ADDR_W:0]      rd_ptr_gray
`endif
);

  localparam int unsigned PTR_W = ADDR_W + 1;

  logic [ADDR_W:0]      rd_ptr_q, rd_ptr_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 led_error_q, led_error_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 accept;
  logic                 underflow;

  fifo_level_calc #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .AE_THRESH (AE_THRESH)
  ) u_level (
    .rd_ptr       (rd_ptr_q),
    .wr_ptr       (wr_ptr),
    .level        (level),
    .empty        (empty),
    .almost_empty (almost_empty)
  );

  assign accept    = pop & ~empty;
  assign underflow = pop & empty;

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    rd_valid_d  = accept;
    led_error_d = led_error_q;
    err_cnt_d   = err_cnt_q;
    if (accept) begin
      rd_ptr_d = PTR_W'(next_ptr(ptr_t'(rd_ptr_q), DEPTH, ADDR_W));
    end
    if (err_clr) begin
      led_error_d = 1'b0;
      err_cnt_d   = '0;
    end
    // An underflow in the clearing cycle counts as the first event after the clear.
    if (underflow) begin
      led_error_d = 1'b1;
      if (err_clr) begin
        err_cnt_d = ERR_CNT_W'(1);
      end else if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      rd_valid_q  <= 1'b0;
      led_error_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      rd_valid_q  <= rd_valid_d;
      led_error_q <= led_error_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign ena_rd    = accept;
  assign addr_rd   = rd_ptr_q[ADDR_W-1:0];
  assign rd_ptr    = rd_ptr_q;
  assign rd_valid  = rd_valid_q;
  assign led_error = led_error_q;
  assign err_cnt   = err_cnt_q;

`ifdef FIFO_RD_GRAY_EN
  if ((DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("fifo_rd_ptr_ctrl: Gray read pointer needs a power-of-2 DEPTH");
  end

  logic [ADDR_W:0] rd_ptr_gray_q, rd_ptr_gray_d;

  always_comb begin
    rd_ptr_gray_d = PTR_W'(bin2gray(ptr_t'(rd_ptr_d)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_gray_q <= '0;
    end else begin
      rd_ptr_gray_q <= rd_ptr_gray_d;
    end
  end

  assign rd_ptr_gray = rd_ptr_gray_q;
`endif

endmodule
